// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the decode/execute boundary.
// Datapath widths, ALU opcodes, operand-select encodings and the stage state.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SRA = 3'b111
    } alu_op_e;

    localparam logic ASEL_RS1 = 1'b0;
    localparam logic ASEL_PC  = 1'b1;
    localparam logic BSEL_RS2 = 1'b0;
    localparam logic BSEL_IMM = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

    // A producer matches a source only if it writes, targets a real register
    // (x0 is hard-wired zero) and the addresses agree.
    function automatic logic addr_match(input logic we,
                                        input logic [RA_W-1:0] rd,
                                        input logic [RA_W-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-source forwarding selector: MEM result, else WB result, else the held value.
// x0 is never forwarded.
module fwd_mux
    import cpu_pkg::*;
(
    input  logic [RA_W-1:0] i_rs,
    input  logic [XLEN-1:0] i_stored,
    input  logic            i_mem_rf_we,
    input  logic [RA_W-1:0] i_mem_rd,
    input  logic [XLEN-1:0] i_mem_wd,
    input  logic            i_wb_rf_we,
    input  logic [RA_W-1:0] i_wb_rd,
    input  logic [XLEN-1:0] i_wb_wd,
    output logic [XLEN-1:0] o_fwd
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = addr_match(i_mem_rf_we, i_mem_rd, i_rs);
    assign w_wb_hit  = addr_match(i_wb_rf_we, i_wb_rd, i_rs);

    // MEM holds the younger producer, so it wins over WB.
    always_comb begin
        o_fwd = i_stored;
        if (w_mem_hit) begin
            o_fwd = i_mem_wd;
        end else if (w_wb_hit) begin
            o_fwd = i_wb_wd;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the combinational ALU, with MEM/WB forwarding
// and a load-use stall.
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_asel,
    input  logic            id_bsel,
    input  logic [2:0]      id_alu_op,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_rf_we,
    input  logic            id_is_load,
    input  logic            mem_rf_we,
    input  logic            mem_is_load,
    input  logic [RA_W-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_wd,
    input  logic            wb_rf_we,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_wd,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_op,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_rf_we,
    output logic            ex_is_load,
    output logic            hazard_stall
);

    // Handshake: a transfer happens on a cycle where valid and ready are both
    // high; valid never depends on ready, ready may depend on the outgoing fire.

    stage_state_e r_state;
    stage_state_e w_state_nxt;

    logic [XLEN-1:0] r_pc;
    logic [RA_W-1:0] r_rs1;
    logic [RA_W-1:0] r_rs2;
    logic [XLEN-1:0] r_rs1_val;
    logic [XLEN-1:0] r_rs2_val;
    logic [XLEN-1:0] r_imm;
    logic            r_asel;
    logic            r_bsel;
    logic [2:0]      r_op;
    logic [RA_W-1:0] r_rd;
    logic            r_rf_we;
    logic            r_is_load;

    logic            w_valid;
    logic            w_fire;
    logic            w_capture;
    logic            w_load;
    logic            w_rs1_used_hit;
    logic            w_rs2_used_hit;
    logic            w_hazard;
    logic [XLEN-1:0] w_rs1_in;
    logic [XLEN-1:0] w_rs2_in;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;

    assign w_valid = (r_state == ST_FULL);

    // rs1 only matters when it feeds operand a; rs2 is conservatively treated
    // as used whenever it is a real register (it may be store data).
    assign w_rs1_used_hit = (r_asel == ASEL_RS1) && (mem_rd == r_rs1);
    assign w_rs2_used_hit = (r_rs2 != '0) && (mem_rd == r_rs2);
    assign w_hazard = w_valid && mem_rf_we && mem_is_load && (mem_rd != '0)
                      && (w_rs1_used_hit || w_rs2_used_hit);

    assign ex_valid     = w_valid && !w_hazard;
    assign hazard_stall = w_hazard;
    assign w_fire       = ex_valid && ex_ready;
    assign id_ready     = !w_valid || w_fire;
    assign w_capture    = id_valid && id_ready;
    assign w_load       = w_capture && !flush;

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_capture) w_state_nxt = ST_FULL;
                ST_FULL:  if (w_fire && !w_capture) w_state_nxt = ST_EMPTY;
                default:  w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A WB write landing in the capture cycle never reached the register-file read.
    assign w_rs1_in = addr_match(wb_rf_we, wb_rd, id_rs1) ? wb_wd : id_rs1_data;
    assign w_rs2_in = addr_match(wb_rf_we, wb_rd, id_rs2) ? wb_wd : id_rs2_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rs1_val <= '0;
            r_rs2_val <= '0;
            r_imm     <= '0;
            r_asel    <= 1'b0;
            r_bsel    <= 1'b0;
            r_op      <= 3'b000;
            r_rd      <= '0;
            r_rf_we   <= 1'b0;
            r_is_load <= 1'b0;
        end else if (w_load) begin
            r_pc      <= id_pc;
            r_rs1     <= id_rs1;
            r_rs2     <= id_rs2;
            r_rs1_val <= w_rs1_in;
            r_rs2_val <= w_rs2_in;
            r_imm     <= id_imm;
            r_asel    <= id_asel;
            r_bsel    <= id_bsel;
            r_op      <= id_alu_op;
            r_rd      <= id_rd;
            r_rf_we   <= id_rf_we;
            r_is_load <= id_is_load;
        end else if (w_valid && !w_fire) begin
            // Producer retires past WB while we wait; keep its value.
            if (addr_match(wb_rf_we, wb_rd, r_rs1)) r_rs1_val <= wb_wd;
            if (addr_match(wb_rf_we, wb_rd, r_rs2)) r_rs2_val <= wb_wd;
        end
    end

    fwd_mux u_fwd_rs1 (
        .i_rs        (r_rs1),
        .i_stored    (r_rs1_val),
        .i_mem_rf_we (mem_rf_we),
        .i_mem_rd    (mem_rd),
        .i_mem_wd    (mem_wd),
        .i_wb_rf_we  (wb_rf_we),
        .i_wb_rd     (wb_rd),
        .i_wb_wd     (wb_wd),
        .o_fwd       (w_fwd_rs1)
    );

    fwd_mux u_fwd_rs2 (
        .i_rs        (r_rs2),
        .i_stored    (r_rs2_val),
        .i_mem_rf_we (mem_rf_we),
        .i_mem_rd    (mem_rd),
        .i_mem_wd    (mem_wd),
        .i_wb_rf_we  (wb_rf_we),
        .i_wb_rd     (wb_rd),
        .i_wb_wd     (wb_wd),
        .o_fwd       (w_fwd_rs2)
    );

    assign alu_a         = (r_asel == ASEL_PC)  ? r_pc  : w_fwd_rs1;
    assign alu_b         = (r_bsel == BSEL_IMM) ? r_imm : w_fwd_rs2;
    assign alu_op        = r_op;
    assign ex_store_data = w_fwd_rs2;
    assign ex_pc         = r_pc;
    assign ex_rd         = r_rd;
    assign ex_rf_we      = r_rf_we;
    assign ex_is_load    = r_is_load;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios with literal expectations, then
// random traffic checked every cycle against a one-slot queue model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_asel, id_bsel;
    logic [2:0]  id_alu_op;
    logic [4:0]  id_rd;
    logic        id_rf_we, id_is_load;
    logic        mem_rf_we, mem_is_load;
    logic [4:0]  mem_rd;
    logic [31:0] mem_wd;
    logic        wb_rf_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wd;
    logic        ex_valid, ex_ready;
    logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
    logic [2:0]  alu_op;
    logic [4:0]  ex_rd;
    logic        ex_rf_we, ex_is_load, hazard_stall;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2;
        logic [31:0] v1, v2;
        logic [31:0] imm;
        logic        asel, bsel;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic        we, ld;
    } m_slot_t;

    m_slot_t slot_q[$];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_asel(id_asel), .id_bsel(id_bsel),
        .id_alu_op(id_alu_op), .id_rd(id_rd), .id_rf_we(id_rf_we),
        .id_is_load(id_is_load),
        .mem_rf_we(mem_rf_we), .mem_is_load(mem_is_load),
        .mem_rd(mem_rd), .mem_wd(mem_wd),
        .wb_rf_we(wb_rf_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
        .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load),
        .hazard_stall(hazard_stall)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Latest architectural value of register a as seen this cycle.
    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] stored);
        if (a == 5'd0) return stored;
        if (mem_rf_we && mem_rd == a) return mem_wd;
        if (wb_rf_we && wb_rd == a) return wb_wd;
        return stored;
    endfunction

    function automatic bit model_hazard();
        m_slot_t s;
        if (slot_q.size() == 0) return 1'b0;
        s = slot_q[0];
        if (!(mem_rf_we && mem_is_load && mem_rd != 5'd0)) return 1'b0;
        return (!s.asel && mem_rd == s.rs1) || (s.rs2 != 5'd0 && mem_rd == s.rs2);
    endfunction

    task automatic model_check();
        bit      haz, exv, rdy;
        m_slot_t s;
        haz = model_hazard();
        exv = (slot_q.size() != 0) && !haz;
        rdy = (slot_q.size() == 0) || (exv && ex_ready);
        chk("ex_valid", 32'(ex_valid), 32'(exv));
        chk("hazard_stall", 32'(hazard_stall), 32'(haz));
        chk("id_ready", 32'(id_ready), 32'(rdy));
        if (exv) begin
            s = slot_q[0];
            chk("alu_a", alu_a, s.asel ? s.pc : fwd(s.rs1, s.v1));
            chk("alu_b", alu_b, s.bsel ? s.imm : fwd(s.rs2, s.v2));
            chk("store_data", ex_store_data, fwd(s.rs2, s.v2));
            chk("alu_op", 32'(alu_op), 32'(s.op));
            chk("ex_pc", ex_pc, s.pc);
            chk("ex_rd", 32'(ex_rd), 32'(s.rd));
            chk("ex_rf_we", 32'(ex_rf_we), 32'(s.we));
            chk("ex_is_load", 32'(ex_is_load), 32'(s.ld));
        end
    endtask

    task automatic model_advance();
        bit      exv, fire, cap;
        m_slot_t n;
        if (!rst_n) begin
            slot_q.delete();
            return;
        end
        exv  = (slot_q.size() != 0) && !model_hazard();
        fire = exv && ex_ready;
        cap  = id_valid && ((slot_q.size() == 0) || fire);
        if (flush) begin
            slot_q.delete();
            return;
        end
        if (fire) void'(slot_q.pop_front());
        if (cap) begin
            n.pc = id_pc; n.rs1 = id_rs1; n.rs2 = id_rs2; n.imm = id_imm;
            n.asel = id_asel; n.bsel = id_bsel; n.op = id_alu_op;
            n.rd = id_rd; n.we = id_rf_we; n.ld = id_is_load;
            n.v1 = (wb_rf_we && wb_rd != 5'd0 && wb_rd == id_rs1) ? wb_wd : id_rs1_data;
            n.v2 = (wb_rf_we && wb_rd != 5'd0 && wb_rd == id_rs2) ? wb_wd : id_rs2_data;
            slot_q.push_back(n);
        end else if (!fire && slot_q.size() != 0 && wb_rf_we && wb_rd != 5'd0) begin
            if (wb_rd == slot_q[0].rs1) slot_q[0].v1 = wb_wd;
            if (wb_rd == slot_q[0].rs2) slot_q[0].v2 = wb_wd;
        end
    endtask

    // Inputs are set just after a falling edge; this checks, advances the
    // model, and returns at the next falling edge.
    task automatic tick();
        #1;
        model_check();
        model_advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid = 0; flush = 0;
        mem_rf_we = 0; mem_is_load = 0; mem_rd = 0; mem_wd = 0;
        wb_rf_we = 0; wb_rd = 0; wb_wd = 0;
        ex_ready = 1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2);
        id_valid = 1; id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2; id_rs2_data = d2;
        id_pc = 32'h1000; id_imm = 32'hFFFF_FFF0; id_asel = 0; id_bsel = 0;
        id_alu_op = 3'b000; id_rd = 5'd9; id_rf_we = 1; id_is_load = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_n = 0;
        idle();
        issue(0, 0, 0, 0);
        id_valid = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst ex_valid", 32'(ex_valid), 32'd0);
        chk("rst hazard", 32'(hazard_stall), 32'd0);
        chk("rst alu_a", alu_a, 32'd0);
        chk("rst alu_b", alu_b, 32'd0);
        chk("rst alu_op", 32'(alu_op), 32'd0);
        chk("rst id_ready", 32'(id_ready), 32'd1);
        rst_n = 1;
        @(negedge clk);

        // Basic capture and issue.
        issue(1, 5, 2, 7); tick();
        id_valid = 0; #1;
        chk("basic ex_valid", 32'(ex_valid), 32'd1);
        chk("basic alu_a", alu_a, 32'd5);
        chk("basic alu_b", alu_b, 32'd7);
        tick();

        // Back-to-back throughput.
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) issue(1, 32'h100 + k, 2, 32'h200 + k);
            else id_valid = 0;
            #1;
            if (k > 0) begin
                if (ex_valid) cnt++;
                chk("b2b alu_a", alu_a, 32'h100 + k - 1);
            end
            tick();
        end
        chk("b2b valid count", cnt, 32'd4);

        // MEM beats WB.
        issue(3, 32'h99, 2, 7); ex_ready = 0; tick();
        id_valid = 0; ex_ready = 0;
        mem_rf_we = 1; mem_rd = 3; mem_wd = 32'h10;
        wb_rf_we = 1; wb_rd = 3; wb_wd = 32'h20;
        #1; chk("fwd mem prio", alu_a, 32'h10);
        tick();
        idle(); tick();

        // x0 is never forwarded.
        issue(0, 0, 0, 0); ex_ready = 0; tick();
        id_valid = 0; ex_ready = 0;
        mem_rf_we = 1; mem_rd = 0; mem_wd = 32'h77;
        wb_rf_we = 1; wb_rd = 0; wb_wd = 32'h66;
        #1; chk("x0 alu_a", alu_a, 32'd0); chk("x0 alu_b", alu_b, 32'd0);
        idle(); tick();

        // Load-use stall then WB forward.
        issue(1, 5, 4, 32'h1111); tick();
        idle(); mem_rf_we = 1; mem_is_load = 1; mem_rd = 4; mem_wd = 32'hDEAD;
        #1;
        chk("lu hazard", 32'(hazard_stall), 32'd1);
        chk("lu ex_valid", 32'(ex_valid), 32'd0);
        chk("lu id_ready", 32'(id_ready), 32'd0);
        tick();
        idle(); wb_rf_we = 1; wb_rd = 4; wb_wd = 32'hABCD;
        #1;
        chk("lu alu_b", alu_b, 32'hABCD);
        chk("lu ex_valid2", 32'(ex_valid), 32'd1);
        tick();

        // Hold refresh while downstream stalls.
        issue(5, 1, 2, 7); ex_ready = 0; tick();
        idle(); ex_ready = 0; wb_rf_we = 1; wb_rd = 5; wb_wd = 32'h55;
        #1; chk("hold id_ready", 32'(id_ready), 32'd0);
        tick();
        for (int k = 0; k < 2; k++) begin
            idle(); ex_ready = 0; wb_rf_we = 1; wb_rd = 9; wb_wd = 32'h99;
            #1;
            chk("hold alu_a", alu_a, 32'h55);
            chk("hold id_ready", 32'(id_ready), 32'd0);
            tick();
        end
        idle(); tick();

        // Flush drops the held and the same-cycle captured instruction.
        issue(1, 1, 2, 2); ex_ready = 0; tick();
        issue(1, 3, 2, 4); ex_ready = 1; flush = 1;
        #1; chk("flush id_ready", 32'(id_ready), 32'd1);
        tick();
        idle(); #1;
        chk("flush ex_valid", 32'(ex_valid), 32'd0);
        chk("flush id_ready2", 32'(id_ready), 32'd1);
        tick();

        // Asynchronous reset in the middle of a stall.
        issue(6, 32'h66, 2, 2); id_pc = 32'h40; tick();
        idle(); mem_rf_we = 1; mem_is_load = 1; mem_rd = 6;
        #1; chk("rst stall hazard", 32'(hazard_stall), 32'd1);
        rst_n = 0;
        #1;
        chk("async ex_valid", 32'(ex_valid), 32'd0);
        chk("async alu_a", alu_a, 32'd0);
        chk("async hazard", 32'(hazard_stall), 32'd0);
        slot_q.delete();
        tick();
        rst_n = 1; idle(); #1;
        chk("post rst ex_valid", 32'(ex_valid), 32'd0);
        chk("post rst id_ready", 32'(id_ready), 32'd1);
        tick();

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            id_valid    = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 19) == 0);
            ex_ready    = ($urandom_range(0, 3) != 0);
            id_pc       = $urandom; id_imm = $urandom;
            id_rs1      = 5'($urandom_range(0, 7));
            id_rs2      = 5'($urandom_range(0, 7));
            id_rs1_data = $urandom; id_rs2_data = $urandom;
            id_asel     = 1'($urandom_range(0, 1));
            id_bsel     = 1'($urandom_range(0, 1));
            id_alu_op   = 3'($urandom_range(0, 7));
            id_rd       = 5'($urandom_range(0, 31));
            id_rf_we    = 1'($urandom_range(0, 1));
            id_is_load  = 1'($urandom_range(0, 1));
            mem_rf_we   = 1'($urandom_range(0, 1));
            mem_is_load = ($urandom_range(0, 2) == 0);
            mem_rd      = 5'($urandom_range(0, 7));
            mem_wd      = $urandom;
            wb_rf_we    = 1'($urandom_range(0, 1));
            wb_rd       = 5'($urandom_range(0, 7));
            wb_wd       = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode and the combinational ALU.
- Captures decoded operands and control under a valid/ready handshake, then drives the ALU's a, b and 3-bit op.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Stalls (emits no valid) on load-use hazards.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard held instruction (branch redirect)
id_valid  in  1  decode presents an instruction
id_ready  out  1  stage can accept an instruction
id_pc  in  XLEN  instruction PC
id_rs1, id_rs2  in  RA_W  source register addresses
id_rs1_data, id_rs2_data  in  XLEN  register-file read data
id_imm  in  XLEN  sign-extended immediate
id_asel  in  1  0: a = rs1, 1: a = pc
id_bsel  in  1  0: b = rs2, 1: b = imm
id_alu_op  in  3  ALU opcode (000 add … 111 sra)
id_rd  in  RA_W  destination register
id_rf_we  in  1  writes rd
id_is_load  in  1  instruction is a load
mem_rf_we, mem_is_load  in  1  MEM-stage write enable and load flag
mem_rd  in  RA_W  MEM-stage destination
mem_wd  in  XLEN  MEM-stage ALU result
wb_rf_we  in  1  WB-stage write enable
wb_rd  in  RA_W  WB-stage destination
wb_wd  in  XLEN  WB-stage write data
ex_valid  out  1  outputs valid this cycle
ex_ready  in  1  downstream accepts
alu_a, alu_b  out  XLEN  ALU operands
alu_op  out  3  ALU opcode
ex_store_data  out  XLEN  forwarded rs2 value, used for stores
ex_pc  out  XLEN  held PC
ex_rd  out  RA_W  held destination
ex_rf_we  out  1  held write enable
ex_is_load  out  1  held load flag
hazard_stall  out  1  load-use hazard active

Behaviour:
- Reset (async, rst_n=0): the valid flag and all held registers clear to 0.
  - Outputs at reset: ex_valid=0, hazard_stall=0, alu_a=alu_b=0, alu_op=000, id_ready=1.
- State is a single valid bit: EMPTY or FULL.
- Handshake:
  - fire_out = ex_valid & ex_ready.
  - id_ready = !valid | fire_out. Capture occurs when id_valid & id_ready.
  - A capture while FULL with fire_out is back-to-back: stays FULL, zero-bubble throughput of 1 instr/cycle.
  - fire_out without capture: FULL → EMPTY.
- flush:
  - Highest priority after reset. Next state is EMPTY and any same-cycle capture is dropped.
  - id_ready is not gated by flush.
- Capture-time write-through: if wb_rf_we, wb_rd == id_rsN and id_rsN != 0, the stored operand takes wb_wd instead of id_rsN_data.
- Hold refresh: while FULL and not firing, a WB write matching a held rsN (nonzero) overwrites the stored rsN value. This preserves the value after the producer retires.
- Forwarding (combinational, per source, x0 never forwarded):
  - MEM match with mem_rf_we → mem_wd.
  - else WB match with wb_rf_we → wb_wd.
  - else stored value.
  - MEM has priority over WB.
- Operand select:
  - alu_a = asel ? ex_pc : fwd_rs1.
  - alu_b = bsel ? imm : fwd_rs2.
  - ex_store_data = fwd_rs2 regardless of bsel.
- Load-use hazard:
  - hazard_stall = valid & mem_rf_we & mem_is_load & mem_rd != 0 & (mem_rd == rs1 used | mem_rd == rs2 used).
  - rs1 used = !asel. rs2 used = !bsel, or the instruction is a store (store_data consumed).
  - To keep this simple, rs2 is treated as used whenever rs2 != 0.
- ex_valid = valid & !hazard_stall. During a stall the stage holds and id_ready = 0.
  - After 1 cycle the load reaches WB and the value is forwarded from WB.
- All held fields (rd, rf_we, is_load, op, sel bits, imm, pc) are unchanged while FULL and not firing.
- Outputs are only meaningful when ex_valid = 1; downstream ignores them otherwise.

Decomposition:
- Shared package cpu_pkg:
  - XLEN, RA_W.
  - ALU opcode constants: ALU_ADD=000, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA=111.
  - ASEL/BSEL encodings.
- One sub-module is natural: fwd_mux (source address, stored data, MEM/WB buses → forwarded value), instantiated twice.

Test Plan:
- Reset, then id_valid with rs1=1 (data 5), rs2=2 (data 7), op=000, bsel=0, ex_ready=1 → next cycle ex_valid=1, alu_a=5, alu_b=7. Back-to-back 4 instrs → 4 consecutive ex_valid cycles.
- Held rs1=3; MEM has rd=3, wd=0x10 and WB has rd=3, wd=0x20 → alu_a=0x10. MEM rd=0 with a matching rs of 0 → no forwarding, alu_a=0.
- Load-use: mem_is_load=1, mem_rd=4, held rs2=4 → hazard_stall=1, ex_valid=0, id_ready=0 for 1 cycle. Next cycle with wb_rd=4, wb_wd=0xABCD → alu_b=0xABCD, ex_valid=1.
- ex_ready=0 for 3 cycles while WB writes rs1's register with 0x55 then leaves → alu_a stays 0x55 after the WB bus changes; id_ready=0 throughout.
- flush asserted concurrently with id_valid capture while FULL → next cycle ex_valid=0, id_ready=1.
- rst_n pulsed low mid-stall → ex_valid=0 and alu_a=0 immediately (asynchronous), stage EMPTY after release.
